// File: rtl/hack_pkg.sv
// Shared Hack definitions: word width, byte width and loader FSM state encoding.
package hack_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        W_HI   = 3'd2,
        W_LO   = 3'd3,
        CHK    = 3'd4,
        RUN    = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Program byte stream with valid/ready handshake.
//  rx_data  : program byte (master -> slave)
//  rx_valid : rx_data valid (master -> slave)
//  rx_ready : slave can accept a byte (slave -> master)
interface instruction_loader_if;
    import hack_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/loader_rom.sv
// Instruction ROM: 2**ADDR_W x WORD_W, synchronous write port, asynchronous read port.
//  clk   : write clock
//  we    : write enable
//  waddr : write address
//  wdata : write data
//  raddr : read address
//  rdata : read data (combinational; a same-cycle write is seen on the next cycle)
module loader_rom
    import hack_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_loader.sv
// Receives a Hack program as a byte stream (length HI/LO, then words HI/LO),
// writes it into the instruction ROM, then releases the CPU from reset and
// serves instruction = ROM[pc] combinationally.
//  clk         : system clock
//  reset       : asynchronous active-low reset
//  rx          : program byte stream (slave side)
//  reload      : in RUN/ERROR, restart the load sequence
//  pc          : CPU program counter
//  instruction : ROM[pc] when pc is inside the loaded program, else 0
//  cpu_reset   : registered active-high CPU reset, low only in RUN
//  loading     : registered, high in the length/word states
//  err         : registered, high in ERROR
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte before the CPU is released.
module instruction_loader
    import hack_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_loader_if.slave  rx,
    input  logic                 reload,
    input  logic [WORD_W-1:0]    pc,
    output logic [WORD_W-1:0]    instruction,
    output logic                 cpu_reset,
    output logic                 loading,
    output logic                 err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    loader_state_t     state, nextState;
    logic [BYTE_W-1:0] hiByte, nextHiByte;
    logic [WORD_W-1:0] wordCount, nextWordCount;
    logic [WORD_W-1:0] wrAddr, nextWrAddr;
    logic [WORD_W-1:0] count, nextCount;
    logic [WORD_W-1:0] lenN_c;
    logic [WORD_W-1:0] romData_c;
    logic              rxReady_c;
    logic              accept_c;
    logic              romWe_c;
    logic              lastByte_c;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum, nextCsum;
`endif

    // Ready whenever the FSM is consuming stream bytes.
    always_comb begin
        rxReady_c = 1'b0;
        case (state)
            LEN_HI, LEN_LO, W_HI, W_LO: rxReady_c = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHK:                        rxReady_c = 1'b1;
`endif
            default:                    rxReady_c = 1'b0;
        endcase
    end

    assign rx.rx_ready = rxReady_c;
    assign accept_c    = rx.rx_valid & rxReady_c;
    assign lenN_c      = {hiByte, rx.rx_data};

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LEN_HI;
            hiByte    <= '0;
            wordCount <= '0;
            wrAddr    <= '0;
            count     <= '0;
            cpu_reset <= 1'b1;
            loading   <= 1'b1;
            err       <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= nextState;
            hiByte    <= nextHiByte;
            wordCount <= nextWordCount;
            wrAddr    <= nextWrAddr;
            count     <= nextCount;
            cpu_reset <= (nextState != RUN);
            loading   <= (nextState == LEN_HI) || (nextState == LEN_LO) ||
                         (nextState == W_HI)   || (nextState == W_LO);
            err       <= (nextState == ERROR);
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum      <= nextCsum;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        nextState     = state;
        nextHiByte    = hiByte;
        nextWordCount = wordCount;
        nextWrAddr    = wrAddr;
        nextCount     = count;
        romWe_c       = 1'b0;
        lastByte_c    = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        nextCsum      = csum;
        if (accept_c && (state != CHK)) begin
            nextCsum = csum ^ rx.rx_data;
        end
`endif

        case (state)
            LEN_HI: begin
                if (accept_c) begin
                    nextHiByte = rx.rx_data;
                    nextState  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept_c) begin
                    // Oversized programs are rejected before any ROM write.
                    if (32'(lenN_c) > DEPTH) begin
                        nextState = ERROR;
                    end else begin
                        nextWordCount = lenN_c;
                        nextWrAddr    = '0;
                        if (lenN_c == '0) begin
                            lastByte_c = 1'b1;
                        end else begin
                            nextState = W_HI;
                        end
                    end
                end
            end
            W_HI: begin
                if (accept_c) begin
                    nextHiByte = rx.rx_data;
                    nextState  = W_LO;
                end
            end
            W_LO: begin
                if (accept_c) begin
                    romWe_c    = 1'b1;
                    nextWrAddr = wrAddr + 16'd1;
                    if (wrAddr == (wordCount - 16'd1)) begin
                        lastByte_c = 1'b1;
                    end else begin
                        nextState = W_HI;
                    end
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept_c) begin
                    if (rx.rx_data == csum) begin
                        nextState = RUN;
                        nextCount = wordCount;
                    end else begin
                        nextState = ERROR;
                    end
                end
            end
`endif
            RUN, ERROR: begin
                // Old ROM contents stay but become unreadable via count=0.
                if (reload) begin
                    nextState     = LEN_HI;
                    nextCount     = '0;
                    nextWordCount = '0;
                    nextWrAddr    = '0;
                    nextHiByte    = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    nextCsum      = '0;
`endif
                end
            end
            default: nextState = LEN_HI;
        endcase

        // End of program data: verify checksum or go live.
        if (lastByte_c) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            nextState = CHK;
`else
            nextState = RUN;
            nextCount = nextWordCount;
`endif
        end
    end

    loader_rom #(.ADDR_W(ADDR_W)) uRom (
        .clk   (clk),
        .we    (romWe_c),
        .waddr (wrAddr[ADDR_W-1:0]),
        .wdata ({hiByte, rx.rx_data}),
        .raddr (pc[ADDR_W-1:0]),
        .rdata (romData_c)
    );

    assign instruction = ((pc < count) && (32'(pc) < DEPTH)) ? romData_c : '0;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboarded bench for instruction_loader (ADDR_W=4): loads, stall,
// empty program, overflow, maximum program, async reset mid-word, checksum.
module tb_instruction_loader;
    import hack_pkg::*;

    localparam int unsigned ADDR_W = 4;

    logic              clk;
    logic              reset;
    logic              reload;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instruction;
    logic              cpu_reset;
    logic              loading;
    logic              err;

    instruction_loader_if rxIf ();

    instruction_loader #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rxIf.slave),
        .reload      (reload),
        .pc          (pc),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .loading     (loading),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nVec  = 0;
    int nMiss = 0;

    logic [WORD_W-1:0] prog[$];
    logic [WORD_W-1:0] expWords[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one byte at a falling edge and hold it until accepted.
    task automatic sendByte(input logic [7:0] b);
        int waitCnt = 0;
        @(negedge clk);
        rxIf.rx_data  = b;
        rxIf.rx_valid = 1'b1;
        while (!rxIf.rx_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!rxIf.rx_ready) begin
            checkVal("rx_ready_timeout", 32'(rxIf.rx_ready), 32'd1);
        end else begin
            @(posedge clk);
        end
        #1 rxIf.rx_valid = 1'b0;
    endtask

    // Stream prog[] in; optionally stall (with reload held) after the HI byte of word stallWord.
    task automatic loadProg(input int stallWord);
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        logic [15:0] len;
        logic [15:0] w;
        int          stallIdx;
        len = 16'(prog.size());
        bytes.push_back(len[15:8]);
        bytes.push_back(len[7:0]);
        foreach (prog[i]) begin
            w = prog[i];
            expWords.push_back(w);
            bytes.push_back(w[15:8]);
            bytes.push_back(w[7:0]);
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        x = 8'h00;
        foreach (bytes[i]) x = x ^ bytes[i];
        bytes.push_back(x);
`endif
        stallIdx = (stallWord >= 0) ? (2 + 2 * stallWord) : -1;
        foreach (bytes[i]) begin
            if (i == bytes.size() - 1) checkVal("cpu_reset_before_last", 32'(cpu_reset), 32'd1);
            sendByte(bytes[i]);
            if (i == stallIdx) begin
                reload = 1'b1;
                repeat (5) @(negedge clk);
                checkVal("stall_loading", 32'(loading), 32'd1);
                checkVal("stall_cpu_reset", 32'(cpu_reset), 32'd1);
                checkVal("stall_rx_ready", 32'(rxIf.rx_ready), 32'd1);
                reload = 1'b0;
            end
        end
        checkVal("run_cpu_reset", 32'(cpu_reset), 32'd0);
        checkVal("run_loading", 32'(loading), 32'd0);
        checkVal("run_rx_ready", 32'(rxIf.rx_ready), 32'd0);
        checkVal("run_err", 32'(err), 32'd0);
    endtask

    // Pop the scoreboard against ROM reads, then check the first address past the program.
    task automatic verifyRom(input int n);
        logic [15:0] e;
        for (int i = 0; i < n; i++) begin
            pc = 16'(i);
            #1;
            e = expWords.pop_front();
            checkVal($sformatf("rom[%0d]", i), 32'(instruction), 32'(e));
        end
        pc = 16'(n);
        #1;
        checkVal("rom_past_end", 32'(instruction), 32'd0);
    endtask

    task automatic reloadPulse();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
        pc = 16'd0;
        #1;
        checkVal("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        checkVal("reload_loading", 32'(loading), 32'd1);
        checkVal("reload_err", 32'(err), 32'd0);
        checkVal("reload_rx_ready", 32'(rxIf.rx_ready), 32'd1);
        checkVal("reload_instr_hidden", 32'(instruction), 32'd0);
    endtask

    initial begin
        reset         = 1'b0;
        reload        = 1'b0;
        pc            = 16'd0;
        rxIf.rx_data  = 8'h00;
        rxIf.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkVal("rst_loading", 32'(loading), 32'd1);
        checkVal("rst_err", 32'(err), 32'd0);
        checkVal("rst_rx_ready", 32'(rxIf.rx_ready), 32'd1);
        checkVal("rst_instruction", 32'(instruction), 32'd0);
        reset = 1'b1;

        // Basic two-word load.
        prog = '{16'h3039, 16'hEC10};
        loadProg(-1);
        verifyRom(2);

        // Stall between HI and LO with reload held high (must be ignored).
        reloadPulse();
        prog = '{16'hABCD};
        loadProg(0);
        verifyRom(1);

        // Empty program.
        reloadPulse();
        prog = {};
        loadProg(-1);
        foreach (prog[i]) expWords.push_back(prog[i]);
        for (int p = 0; p < 3; p++) begin
            pc = 16'(p * 5);
            #1;
            checkVal("empty_instr", 32'(instruction), 32'd0);
        end

        // Overflow: 17 words with a 16-deep ROM.
        reloadPulse();
        sendByte(8'h00);
        sendByte(8'h11);
        checkVal("ovf_err", 32'(err), 32'd1);
        checkVal("ovf_rx_ready", 32'(rxIf.rx_ready), 32'd0);
        checkVal("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        checkVal("ovf_loading", 32'(loading), 32'd0);
        reloadPulse();

        // Maximum program fills the ROM.
        prog = {};
        for (int i = 0; i < 16; i++) prog.push_back(16'($urandom));
        loadProg(-1);
        verifyRom(16);

        // Async reset after a HI byte aborts the word.
        reloadPulse();
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h55);
        reset = 1'b0;
        #1;
        checkVal("arst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkVal("arst_loading", 32'(loading), 32'd1);
        checkVal("arst_instr", 32'(instruction), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        prog = '{16'h1234};
        loadProg(-1);
        verifyRom(1);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Explicit checksum match and mismatch.
        reloadPulse();
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h12);
        sendByte(8'h34);
        sendByte(8'h27);
        checkVal("csum_ok_cpu_reset", 32'(cpu_reset), 32'd0);
        checkVal("csum_ok_err", 32'(err), 32'd0);
        reloadPulse();
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h12);
        sendByte(8'h34);
        sendByte(8'h00);
        checkVal("csum_bad_err", 32'(err), 32'd1);
        checkVal("csum_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

        checkVal("scoreboard_empty", 32'(expWords.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
